segasys1_prgdec_ctl: RTL and testbench
======================================

# segasys1_prgdec_ctl

Configuration controller for the System 1 program-ROM decryptor. It watches the ROM download stream on the system clock and routes decryption-table bytes to the table RAM write ports. From the table contents it decides the decryption mode: bypass, type 1 or type 2. It holds the main CPU in wait until the mode is committed. It sits between the download interface and the decryptor/CPU wait logic and replaces the free-running type-detect counters.

## Interface
- DECTBL_ADRS, 25'h2C100: first byte of the decryption-table region; a second 128-byte half starts at DECTBL_ADRS+128.
- THRESH, 128: run length at or above which a mode is selected.
- SETTLE, 4: clk cycles between mode commit and CPU release (1..255).

- clk  in  1  system clock; every input is sampled on its rising edge.
- RESET_N  in  1  reset; synchronous, active-low.
- dl_active  in  1  ROM download in progress (level).
- ROMEN  in  1  download byte strobe, one clk wide per byte.
- ROMAD  in  25  download byte address.
- ROMDT  in  8  download byte.
- tbl_wa  out  7  table write address, registered.
- tbl_wd  out  8  table write data, registered.
- tbl1_we  out  1  type-1 table write enable.
- tbl2x_we  out  1  type-2 XOR table write enable.
- tbl2s_we  out  1  type-2 swap table write enable.
- dec_mode  out  2  0 = bypass, 1 = type 1, 2 = type 2; 3 is never driven.
- cpu_hold  out  1  CPU wait/reset request.
- cfg_done  out  1  mode committed and CPU released.

## Operation
- States: IDLE, LOAD, DECIDE, SETTLE, RUN.
- Reset values, active on the clk edge that samples RESET_N=0:
  - state=IDLE, dec_mode=1, cpu_hold=1, cfg_done=0.
  - all write enables 0, tbl_wa=0, tbl_wd=0.
  - run0=0, run2=0, settle counter 0.
- IDLE: when dl_active=1, go to LOAD, clear run0/run2 and hold cpu_hold=1. dl_active already high when reset releases also enters LOAD; the partial count is accepted.
- LOAD, per ROMEN=1 byte:
  - ROMAD >= DECTBL_ADRS:
    - run0 = (ROMDT!=0) ? 0 : run0+1.
    - run2 = (ROMDT>=24) ? 0 : run2+1.
    - Both are 16-bit and saturate at 16'hFFFF (no wrap).
  - ROMAD < DECTBL_ADRS: run0 and run2 are cleared.
  - Write routing, equality on ROMAD[24:7]:
    - First half (DECTBL_ADRS..+127): tbl1_we=1 and tbl2x_we=1.
    - Second half (DECTBL_ADRS+128..+255): tbl2s_we=1.
    - tbl_wa=ROMAD[6:0], tbl_wd=ROMDT.
  - ROMEN=0 leaves the counters unchanged and all enables 0.
  - On dl_active=0, go to DECIDE. An ROMEN in the same cycle is still processed.
- DECIDE, one cycle; priority order:
  - run0>=THRESH gives dec_mode=0.
  - else run2>=THRESH gives dec_mode=2.
  - else dec_mode=1.
  - Then go to SETTLE and load the settle counter with SETTLE.
- SETTLE: decrement each cycle; on reaching 0 go to RUN.
- RUN: cpu_hold=0, cfg_done=1; dec_mode is stable.
- dl_active=1 in DECIDE, SETTLE or RUN:
  - Next cycle: LOAD, cpu_hold=1, cfg_done=0, counters cleared.
  - dec_mode keeps its old value until the next DECIDE.
- ROMEN outside LOAD is ignored: no writes, no counting.

## Timing
- Write enables, tbl_wa and tbl_wd follow the ROMEN byte by exactly 1 clk and are 1 clk wide. Back-to-back ROMEN bytes produce back-to-back writes.
- dl_active fall sampled at edge N:
  - DECIDE occupies N+1.
  - dec_mode is updated at edge N+2.
  - cpu_hold falls and cfg_done rises at edge N+2+SETTLE.
- dl_active rise in RUN sampled at edge N: cpu_hold=1 at edge N+1.
- Synchronous reset mid-LOAD aborts immediately. Any table write in flight is dropped (its enable registers 0). No stale mode survives: dec_mode returns to 1.

## Test plan
- Download of 0x2C200 bytes with the table region all 0x00, dl_active then falls:
  - run0 saturates past 128, dec_mode=0.
  - cpu_hold falls exactly SETTLE+2 clk after the fall.
  - 256 table writes occur: 128 on tbl1_we/tbl2x_we, 128 on tbl2s_we.
- Table bytes all 0x05 (in 0..23): dec_mode=2. A byte 0x55 at 0x2C1A0 is written as tbl2s_we=1, tbl_wa=0x20, tbl_wd=0x55, one clk after its ROMEN.
- Table bytes 0x80 repeating: both runs stay 0, dec_mode=1. A 0x33 at 0x2C105 gives tbl1_we=tbl2x_we=1, tbl_wa=0x05.
- Run boundary: 127 zeros ending the image gives dec_mode=1. 128 zeros gives dec_mode=0. 128 bytes of 0x18 (=24) gives dec_mode=1.
- Re-download while in RUN: cpu_hold=1 one clk after the dl_active rise. dec_mode holds its old value until the new DECIDE, then takes the new result.
- RESET_N=0 for 1 clk mid-LOAD:
  - All outputs return to reset values on that edge; no write enable is asserted afterwards.
  - With dl_active still high, LOAD is re-entered with counts restarting from 0.

Source files
------------

// File: rtl/segasys1_prgdec_ctl.sv
// System 1 program-ROM decryptor configuration controller: routes decryption-table
// bytes from the download stream to the table RAMs and commits the decryption mode.
module segasys1_prgdec_ctl #(
  parameter logic [24:0] DECTBL_ADRS = 25'h2C100,
  parameter int unsigned THRESH      = 128,
  parameter int unsigned SETTLE      = 4
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        dl_active,
  input  logic        ROMEN,
  input  logic [24:0] ROMAD,
  input  logic [7:0]  ROMDT,
  output logic [6:0]  tbl_wa,
  output logic [7:0]  tbl_wd,
  output logic        tbl1_we,
  output logic        tbl2x_we,
  output logic        tbl2s_we,
  output logic [1:0]  dec_mode,
  output logic        cpu_hold,
  output logic        cfg_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DECIDE,
    S_SETTLE,
    S_RUN
  } state_t;

  localparam logic [24:0] HALF1_ADRS  = DECTBL_ADRS + 25'd128;
  localparam logic [17:0] HALF0_PAGE  = DECTBL_ADRS[24:7];
  localparam logic [17:0] HALF1_PAGE  = HALF1_ADRS[24:7];
  localparam logic [15:0] THRESH_W    = 16'(THRESH);
  localparam logic [7:0]  SETTLE_W    = 8'(SETTLE);
  localparam logic [1:0]  MODE_BYPASS = 2'd0;
  localparam logic [1:0]  MODE_TYPE1  = 2'd1;
  localparam logic [1:0]  MODE_TYPE2  = 2'd2;

  state_t      state_q, state_d;
  logic        dl_q, dl_d;
  logic [15:0] run0_q, run0_d;
  logic [15:0] run2_q, run2_d;
  logic [7:0]  settle_q, settle_d;
  logic [1:0]  dec_mode_q, dec_mode_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        cfg_done_q, cfg_done_d;
  logic        tbl1_we_q, tbl1_we_d;
  logic        tbl2x_we_q, tbl2x_we_d;
  logic        tbl2s_we_q, tbl2s_we_d;
  logic [6:0]  tbl_wa_q, tbl_wa_d;
  logic [7:0]  tbl_wd_q, tbl_wd_d;

  logic in_tbl_space;
  logic hit_half0;
  logic hit_half1;

  assign in_tbl_space = (ROMAD >= DECTBL_ADRS);
  assign hit_half0    = (ROMAD[24:7] == HALF0_PAGE);
  assign hit_half1    = (ROMAD[24:7] == HALF1_PAGE);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The FSM acts on a registered copy of dl_active, so every state change lags
  // the sampled level by one clk while byte strobes are handled immediately.
  always_comb begin
    state_d    = state_q;
    dl_d       = dl_active;
    run0_d     = run0_q;
    run2_d     = run2_q;
    settle_d   = settle_q;
    dec_mode_d = dec_mode_q;
    cpu_hold_d = cpu_hold_q;
    cfg_done_d = cfg_done_q;
    tbl1_we_d  = 1'b0;
    tbl2x_we_d = 1'b0;
    tbl2s_we_d = 1'b0;
    tbl_wa_d   = tbl_wa_q;
    tbl_wd_d   = tbl_wd_q;

    case (state_q)
      S_IDLE: begin
        if (dl_q) begin
          state_d    = S_LOAD;
          run0_d     = 16'd0;
          run2_d     = 16'd0;
          cpu_hold_d = 1'b1;
        end
      end

      S_LOAD: begin
        if (ROMEN) begin
          if (in_tbl_space) begin
            run0_d = (ROMDT != 8'd0)  ? 16'd0 : sat_inc(run0_q);
            run2_d = (ROMDT >= 8'd24) ? 16'd0 : sat_inc(run2_q);
          end else begin
            run0_d = 16'd0;
            run2_d = 16'd0;
          end
          if (hit_half0) begin
            tbl1_we_d  = 1'b1;
            tbl2x_we_d = 1'b1;
          end else if (hit_half1) begin
            tbl2s_we_d = 1'b1;
          end
          if (hit_half0 || hit_half1) begin
            tbl_wa_d = ROMAD[6:0];
            tbl_wd_d = ROMDT;
          end
        end
        if (!dl_q) state_d = S_DECIDE;
      end

      S_DECIDE, S_SETTLE, S_RUN: begin
        if (dl_q) begin
          state_d    = S_LOAD;
          run0_d     = 16'd0;
          run2_d     = 16'd0;
          cpu_hold_d = 1'b1;
          cfg_done_d = 1'b0;
        end else if (state_q == S_DECIDE) begin
          if (run0_q >= THRESH_W)      dec_mode_d = MODE_BYPASS;
          else if (run2_q >= THRESH_W) dec_mode_d = MODE_TYPE2;
          else                         dec_mode_d = MODE_TYPE1;
          settle_d = SETTLE_W;
          state_d  = S_SETTLE;
        end else if (state_q == S_SETTLE) begin
          if (settle_q <= 8'd1) begin
            settle_d   = 8'd0;
            state_d    = S_RUN;
            cpu_hold_d = 1'b0;
            cfg_done_d = 1'b1;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      dl_q       <= 1'b0;
      run0_q     <= 16'd0;
      run2_q     <= 16'd0;
      settle_q   <= 8'd0;
      dec_mode_q <= MODE_TYPE1;
      cpu_hold_q <= 1'b1;
      cfg_done_q <= 1'b0;
      tbl1_we_q  <= 1'b0;
      tbl2x_we_q <= 1'b0;
      tbl2s_we_q <= 1'b0;
      tbl_wa_q   <= 7'd0;
      tbl_wd_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      dl_q       <= dl_d;
      run0_q     <= run0_d;
      run2_q     <= run2_d;
      settle_q   <= settle_d;
      dec_mode_q <= dec_mode_d;
      cpu_hold_q <= cpu_hold_d;
      cfg_done_q <= cfg_done_d;
      tbl1_we_q  <= tbl1_we_d;
      tbl2x_we_q <= tbl2x_we_d;
      tbl2s_we_q <= tbl2s_we_d;
      tbl_wa_q   <= tbl_wa_d;
      tbl_wd_q   <= tbl_wd_d;
    end
  end

  assign tbl_wa   = tbl_wa_q;
  assign tbl_wd   = tbl_wd_q;
  assign tbl1_we  = tbl1_we_q;
  assign tbl2x_we = tbl2x_we_q;
  assign tbl2s_we = tbl2s_we_q;
  assign dec_mode = dec_mode_q;
  assign cpu_hold = cpu_hold_q;
  assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_segasys1_prgdec_ctl.sv
// Directed bench for segasys1_prgdec_ctl: table routing, mode decision thresholds,
// settle timing, re-download and mid-load reset.
module tb_segasys1_prgdec_ctl;

  localparam int SETTLE_CYC = 4;

  logic        clk;
  logic        RESET_N;
  logic        dl_active;
  logic        ROMEN;
  logic [24:0] ROMAD;
  logic [7:0]  ROMDT;
  logic [6:0]  tbl_wa;
  logic [7:0]  tbl_wd;
  logic        tbl1_we;
  logic        tbl2x_we;
  logic        tbl2s_we;
  logic [1:0]  dec_mode;
  logic        cpu_hold;
  logic        cfg_done;

  int total = 0;
  int bad   = 0;
  int n_we1  = 0;
  int n_we2x = 0;
  int n_we2s = 0;

  segasys1_prgdec_ctl dut (
    .clk      (clk),
    .RESET_N  (RESET_N),
    .dl_active(dl_active),
    .ROMEN    (ROMEN),
    .ROMAD    (ROMAD),
    .ROMDT    (ROMDT),
    .tbl_wa   (tbl_wa),
    .tbl_wd   (tbl_wd),
    .tbl1_we  (tbl1_we),
    .tbl2x_we (tbl2x_we),
    .tbl2s_we (tbl2s_we),
    .dec_mode (dec_mode),
    .cpu_hold (cpu_hold),
    .cfg_done (cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count registered write strobes, one per clk they are high.
  always @(posedge clk) begin
    if (tbl1_we)  n_we1++;
    if (tbl2x_we) n_we2x++;
    if (tbl2s_we) n_we2s++;
  end

  // Drivers enter and leave at a falling edge; outputs then reflect the byte.
  task automatic drive_byte(input logic [24:0] a, input logic [7:0] d);
    ROMEN = 1'b1;
    ROMAD = a;
    ROMDT = d;
    @(negedge clk);
    ROMEN = 1'b0;
  endtask

  task automatic stream(input logic [24:0] base, input int n, input logic [7:0] d);
    for (int i = 0; i < n; i++) drive_byte(base + 25'(i), d);
  endtask

  task automatic start_download;
    dl_active = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // k counts edges from the one that samples dl_active low (k=0).
  task automatic finish_download(input logic with_byte, input logic [24:0] a,
                                 input logic [7:0] d, output logic [1:0] mode_k1,
                                 output logic [1:0] mode_k2, output logic swe_k0,
                                 output int fall_k, output logic done_at_fall);
    mode_k1 = 2'd3;
    mode_k2 = 2'd3;
    swe_k0 = 1'b0;
    fall_k = -1;
    done_at_fall = 1'b0;
    dl_active = 1'b0;
    ROMEN = with_byte;
    ROMAD = a;
    ROMDT = d;
    for (int k = 0; k <= 64; k++) begin
      @(posedge clk);
      #1;
      ROMEN = 1'b0;
      if (k == 0) swe_k0 = tbl2s_we;
      if (k == 1) mode_k1 = dec_mode;
      if (k == 2) mode_k2 = dec_mode;
      if (!cpu_hold) begin
        fall_k = k;
        done_at_fall = cfg_done;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    dl_active = 1'b0;
    ROMEN = 1'b0;
    ROMAD = 25'd0;
    ROMDT = 8'd0;
    repeat (3) @(negedge clk);
    total++; if (dec_mode !== 2'd1) begin bad++; $display("[TB] FAIL reset_dec_mode: got %0d want 1", dec_mode); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL reset_cpu_hold: got %0b want 1", cpu_hold); end
    total++; if (cfg_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_cfg_done: got %0b want 0", cfg_done); end
    total++; if ({tbl1_we, tbl2x_we, tbl2s_we} !== 3'b000) begin bad++; $display("[TB] FAIL reset_we: got %b want 000", {tbl1_we, tbl2x_we, tbl2s_we}); end
    total++; if ({tbl_wa, tbl_wd} !== 15'd0) begin bad++; $display("[TB] FAIL reset_wa_wd: got %0h/%0h want 0/0", tbl_wa, tbl_wd); end
    RESET_N = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({cpu_hold, cfg_done} !== 2'b10) begin bad++; $display("[TB] FAIL idle_hold: got %b want 10", {cpu_hold, cfg_done}); end
  endtask

  task automatic test_zero_table;
    logic [1:0] m1, m2;
    logic swe, dn;
    int fk, s1, s2x, s2s;
    s1 = n_we1; s2x = n_we2x; s2s = n_we2s;
    start_download;
    stream(25'h2C0F0, 16, 8'hFF);
    stream(25'h2C100, 256, 8'h00);
    finish_download(1'b0, 25'd0, 8'd0, m1, m2, swe, fk, dn);
    total++; if (m1 !== 2'd1) begin bad++; $display("[TB] FAIL zero_mode_old: got %0d want 1", m1); end
    total++; if (m2 !== 2'd0) begin bad++; $display("[TB] FAIL zero_mode_new: got %0d want 0", m2); end
    total++; if (fk !== SETTLE_CYC + 2) begin bad++; $display("[TB] FAIL zero_hold_fall: got %0d want %0d", fk, SETTLE_CYC + 2); end
    total++; if (dn !== 1'b1) begin bad++; $display("[TB] FAIL zero_cfg_done: got %0b want 1", dn); end
    total++; if (n_we1 - s1 !== 128) begin bad++; $display("[TB] FAIL zero_cnt_we1: got %0d want 128", n_we1 - s1); end
    total++; if (n_we2x - s2x !== 128) begin bad++; $display("[TB] FAIL zero_cnt_we2x: got %0d want 128", n_we2x - s2x); end
    total++; if (n_we2s - s2s !== 128) begin bad++; $display("[TB] FAIL zero_cnt_we2s: got %0d want 128", n_we2s - s2s); end
  endtask

  task automatic test_type2;
    logic [1:0] m1, m2;
    logic swe, dn;
    int fk;
    start_download;
    stream(25'h2C100, 'hA0, 8'h05);
    drive_byte(25'h2C1A0, 8'h55);
    total++; if ({tbl1_we, tbl2x_we, tbl2s_we} !== 3'b001) begin bad++; $display("[TB] FAIL t2_we: got %b want 001", {tbl1_we, tbl2x_we, tbl2s_we}); end
    total++; if (tbl_wa !== 7'h20) begin bad++; $display("[TB] FAIL t2_wa: got %0h want 20", tbl_wa); end
    total++; if (tbl_wd !== 8'h55) begin bad++; $display("[TB] FAIL t2_wd: got %0h want 55", tbl_wd); end
    stream(25'h2C1A1, 95, 8'h05);
    stream(25'h2C200, 128, 8'h05);
    finish_download(1'b0, 25'd0, 8'd0, m1, m2, swe, fk, dn);
    total++; if (m1 !== 2'd0) begin bad++; $display("[TB] FAIL t2_mode_old: got %0d want 0", m1); end
    total++; if (m2 !== 2'd2) begin bad++; $display("[TB] FAIL t2_mode_new: got %0d want 2", m2); end
    total++; if (fk !== SETTLE_CYC + 2) begin bad++; $display("[TB] FAIL t2_hold_fall: got %0d want %0d", fk, SETTLE_CYC + 2); end
  endtask

  task automatic test_type1;
    logic [1:0] m1, m2;
    logic swe, dn;
    int fk;
    start_download;
    stream(25'h2C100, 5, 8'h80);
    drive_byte(25'h2C105, 8'h33);
    total++; if ({tbl1_we, tbl2x_we, tbl2s_we} !== 3'b110) begin bad++; $display("[TB] FAIL t1_we: got %b want 110", {tbl1_we, tbl2x_we, tbl2s_we}); end
    total++; if (tbl_wa !== 7'h05) begin bad++; $display("[TB] FAIL t1_wa: got %0h want 5", tbl_wa); end
    total++; if (tbl_wd !== 8'h33) begin bad++; $display("[TB] FAIL t1_wd: got %0h want 33", tbl_wd); end
    stream(25'h2C106, 250, 8'h80);
    finish_download(1'b0, 25'd0, 8'd0, m1, m2, swe, fk, dn);
    total++; if (m1 !== 2'd2) begin bad++; $display("[TB] FAIL t1_mode_old: got %0d want 2", m1); end
    total++; if (m2 !== 2'd1) begin bad++; $display("[TB] FAIL t1_mode_new: got %0d want 1", m2); end
  endtask

  task automatic test_run_boundary;
    logic [1:0] m1, m2;
    logic swe, dn;
    int fk;
    start_download;
    drive_byte(25'h2C100, 8'hFF);
    stream(25'h2C101, 127, 8'h00);
    finish_download(1'b0, 25'd0, 8'd0, m1, m2, swe, fk, dn);
    total++; if (m2 !== 2'd1) begin bad++; $display("[TB] FAIL run127_mode: got %0d want 1", m2); end
    // The 128th zero arrives in the same clk that dl_active falls.
    start_download;
    drive_byte(25'h2C100, 8'hFF);
    stream(25'h2C101, 127, 8'h00);
    finish_download(1'b1, 25'h2C180, 8'h00, m1, m2, swe, fk, dn);
    total++; if (swe !== 1'b1) begin bad++; $display("[TB] FAIL run128_last_write: got %0b want 1", swe); end
    total++; if (m2 !== 2'd0) begin bad++; $display("[TB] FAIL run128_mode: got %0d want 0", m2); end
    start_download;
    drive_byte(25'h2C100, 8'hFF);
    stream(25'h2C101, 128, 8'h18);
    finish_download(1'b0, 25'd0, 8'd0, m1, m2, swe, fk, dn);
    total++; if (m1 !== 2'd0) begin bad++; $display("[TB] FAIL run24_mode_old: got %0d want 0", m1); end
    total++; if (m2 !== 2'd1) begin bad++; $display("[TB] FAIL run24_mode: got %0d want 1", m2); end
  endtask

  task automatic test_redownload;
    logic [1:0] m1, m2;
    logic swe, dn;
    int fk;
    drive_byte(25'h2C105, 8'h77);
    total++; if ({tbl1_we, tbl2x_we, tbl2s_we} !== 3'b000) begin bad++; $display("[TB] FAIL run_romen_ignored: got %b want 000", {tbl1_we, tbl2x_we, tbl2s_we}); end
    dl_active = 1'b1;
    @(posedge clk); #1;
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("[TB] FAIL redl_hold_early: got %0b want 0", cpu_hold); end
    @(posedge clk); #1;
    total++; if ({cpu_hold, cfg_done} !== 2'b10) begin bad++; $display("[TB] FAIL redl_hold: got %b want 10", {cpu_hold, cfg_done}); end
    @(negedge clk);
    stream(25'h2C100, 256, 8'h00);
    total++; if (dec_mode !== 2'd1) begin bad++; $display("[TB] FAIL redl_mode_held: got %0d want 1", dec_mode); end
    finish_download(1'b0, 25'd0, 8'd0, m1, m2, swe, fk, dn);
    total++; if (m1 !== 2'd1) begin bad++; $display("[TB] FAIL redl_mode_old: got %0d want 1", m1); end
    total++; if (m2 !== 2'd0) begin bad++; $display("[TB] FAIL redl_mode_new: got %0d want 0", m2); end
    total++; if (fk !== SETTLE_CYC + 2) begin bad++; $display("[TB] FAIL redl_hold_fall: got %0d want %0d", fk, SETTLE_CYC + 2); end
  endtask

  task automatic test_reset_mid_load;
    logic [1:0] m1, m2;
    logic swe, dn;
    int fk;
    start_download;
    stream(25'h2C100, 100, 8'h00);
    RESET_N = 1'b0;
    drive_byte(25'h2C164, 8'h00);
    total++; if ({tbl1_we, tbl2x_we, tbl2s_we} !== 3'b000) begin bad++; $display("[TB] FAIL rst_we_dropped: got %b want 000", {tbl1_we, tbl2x_we, tbl2s_we}); end
    total++; if ({tbl_wa, tbl_wd} !== 15'd0) begin bad++; $display("[TB] FAIL rst_wa_wd: got %0h/%0h want 0/0", tbl_wa, tbl_wd); end
    total++; if (dec_mode !== 2'd1) begin bad++; $display("[TB] FAIL rst_dec_mode: got %0d want 1", dec_mode); end
    total++; if ({cpu_hold, cfg_done} !== 2'b10) begin bad++; $display("[TB] FAIL rst_hold: got %b want 10", {cpu_hold, cfg_done}); end
    RESET_N = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({tbl1_we, tbl2x_we, tbl2s_we} !== 3'b000) begin bad++; $display("[TB] FAIL rst_no_we_after: got %b want 000", {tbl1_we, tbl2x_we, tbl2s_we}); end
    stream(25'h2C100, 127, 8'h00);
    finish_download(1'b0, 25'd0, 8'd0, m1, m2, swe, fk, dn);
    total++; if (m2 !== 2'd1) begin bad++; $display("[TB] FAIL rst_count_restart: got %0d want 1", m2); end
    total++; if (fk !== SETTLE_CYC + 2) begin bad++; $display("[TB] FAIL rst_hold_fall: got %0d want %0d", fk, SETTLE_CYC + 2); end
    total++; if (dn !== 1'b1) begin bad++; $display("[TB] FAIL rst_cfg_done: got %0b want 1", dn); end
  endtask

  initial begin
    RESET_N = 1'b0;
    dl_active = 1'b0;
    ROMEN = 1'b0;
    ROMAD = 25'd0;
    ROMDT = 8'd0;
    test_reset;
    test_zero_table;
    test_type2;
    test_type1;
    test_run_boundary;
    test_redownload;
    test_reset_mid_load;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
